wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between two sources.
  - The EX/WB pipeline result, which is in-order and has priority.
  - A multi-cycle unit, such as a multiplier or load unit, which uses a valid/ready handshake.
- Multi-cycle results wait in a small FIFO until a free write-port slot appears.
- A starvation guard freezes the pipeline for one cycle to force a drain.
- Sits between the EX/WB stage, the multi-cycle unit and the register file; also feeds the hazard unit.

---
 rtl/wb_port_arbiter_pkg.sv | 12 +
 rtl/wb_port_arbiter_result_fifo.sv | 93 +++++++++
 rtl/wb_port_arbiter.sv | 139 +++++++++++++
 tb/tb_wb_port_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared sizes and FSM encoding for the register-file write-port arbiter.
package wb_port_arbiter_pkg;

    localparam int unsigned WB_DSIZE = 16;
    localparam int unsigned WB_ASIZE = 4;

    typedef enum logic {
        WB_NORMAL = 1'b0,
        WB_STALL  = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_port_arbiter_result_fifo.sv
// Small FIFO holding multi-cycle results until the write port is free;
// also reports whether a probed register has a write still queued.
module wb_result_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned DSIZE = WB_DSIZE,
    parameter int unsigned ASIZE = WB_ASIZE,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [ASIZE-1:0] push_waddr,
    input  logic [DSIZE-1:0] push_data,
    input  logic             pop,
    output logic [ASIZE-1:0] head_waddr,
    output logic [DSIZE-1:0] head_data,
    output logic             empty,
    output logic             full,
    input  logic [ASIZE-1:0] query_addr,
    output logic             pending_hit
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0]                 wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]                 rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                 count_q, count_d;
    logic [DEPTH-1:0][ASIZE-1:0]   waddr_q, waddr_d;
    logic [DEPTH-1:0][DSIZE-1:0]   data_q, data_d;
    logic [DEPTH-1:0]              match;
    logic                          do_push, do_pop;

    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;
    assign head_waddr = waddr_q[rd_ptr_q];
    assign head_data  = data_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        waddr_d  = waddr_q;
        data_d   = data_q;
        if (do_push) begin
            waddr_d[wr_ptr_q] = push_waddr;
            data_d[wr_ptr_q]  = push_data;
            wr_ptr_d          = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // An entry is live when its distance from the read pointer is below count.
    always_comb begin
        logic [PW-1:0] offset;
        offset = '0;
        match  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offset   = PW'(i) - rd_ptr_q;
            match[i] = (CW'(offset) < count_q) && (waddr_q[i] == query_addr);
        end
    end

    assign pending_hit = (query_addr != '0) && (|match);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        waddr_q <= waddr_d;
        data_q  <= data_d;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the in-order
// EX/WB result and queued multi-cycle results, with a starvation stall.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned DSIZE        = WB_DSIZE,
    parameter int unsigned ASIZE        = WB_ASIZE,
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    input  logic [ASIZE-1:0] alu_waddr,
    input  logic [DSIZE-1:0] alu_data,
    input  logic             mc_valid,
    output logic             mc_ready,
    input  logic [ASIZE-1:0] mc_waddr,
    input  logic [DSIZE-1:0] mc_data,
    input  logic [ASIZE-1:0] query_addr,
    output logic             pending_hit,
    output logic             pipe_stall,
    output logic             rf_wen,
    output logic [ASIZE-1:0] rf_waddr,
    output logic [DSIZE-1:0] rf_wdata
);

    localparam int unsigned WW = $clog2(STARVE_LIMIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(STARVE_LIMIT - 1);

    wb_state_e         state_q, state_d;
    logic [WW-1:0]     wait_cnt_q, wait_cnt_d;
    logic              rf_wen_q, rf_wen_d;
    logic [ASIZE-1:0]  rf_waddr_q, rf_waddr_d;
    logic [DSIZE-1:0]  rf_wdata_q, rf_wdata_d;

    logic              fifo_empty, fifo_full;
    logic [ASIZE-1:0]  head_waddr;
    logic [DSIZE-1:0]  head_data;
    logic              alu_req, pop, push;

    assign alu_req  = alu_valid && (alu_waddr != '0);
    assign mc_ready = !fifo_full;
    // Writes to r0 still complete the handshake but are dropped here.
    assign push     = mc_valid && mc_ready && (mc_waddr != '0);

    wb_result_fifo #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_waddr  (mc_waddr),
        .push_data   (mc_data),
        .pop         (pop),
        .head_waddr  (head_waddr),
        .head_data   (head_data),
        .empty       (fifo_empty),
        .full        (fifo_full),
        .query_addr  (query_addr),
        .pending_hit (pending_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WB_NORMAL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = WB_NORMAL;
        if (state_q == WB_NORMAL && !fifo_empty && !pop && wait_cnt_q == WAIT_MAX) begin
            state_d = WB_STALL;
        end
    end

    always_comb begin
        pipe_stall = (state_q == WB_STALL);
        pop        = 1'b0;
        rf_wen_d   = 1'b0;
        rf_waddr_d = '0;
        rf_wdata_d = '0;
        case (state_q)
            WB_NORMAL: begin
                if (alu_req) begin
                    rf_wen_d   = 1'b1;
                    rf_waddr_d = alu_waddr;
                    rf_wdata_d = alu_data;
                end else if (!fifo_empty) begin
                    pop        = 1'b1;
                    rf_wen_d   = 1'b1;
                    rf_waddr_d = head_waddr;
                    rf_wdata_d = head_data;
                end
            end
            WB_STALL: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    rf_wen_d   = 1'b1;
                    rf_waddr_d = head_waddr;
                    rf_wdata_d = head_data;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (pop || fifo_empty) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q < WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + WW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_wen   = rf_wen_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench: expected register-file writes (with their cycle) are queued
// by the stimulus and matched by a monitor on every observed write.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [3:0]  alu_waddr;
    logic [15:0] alu_data;
    logic        mc_valid;
    logic        mc_ready;
    logic [3:0]  mc_waddr;
    logic [15:0] mc_data;
    logic [3:0]  query_addr;
    logic        pending_hit;
    logic        pipe_stall;
    logic        rf_wen;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    wb_port_arbiter #(
        .DSIZE        (16),
        .ASIZE        (4),
        .DEPTH        (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_waddr   (alu_waddr),
        .alu_data    (alu_data),
        .mc_valid    (mc_valid),
        .mc_ready    (mc_ready),
        .mc_waddr    (mc_waddr),
        .mc_data     (mc_data),
        .query_addr  (query_addr),
        .pending_hit (pending_hit),
        .pipe_stall  (pipe_stall),
        .rf_wen      (rf_wen),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [3:0] a, input logic [15:0] d, input int c);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every write must match the oldest expectation.
    always @(negedge clk) begin
        if (rf_wen === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none (cycle %0d)",
                         rf_waddr, rf_wdata, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wr_addr", int'(rf_waddr), int'(e.addr));
                chk("wr_data", int'(rf_wdata), int'(e.data));
                chk("wr_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int aidx[12];
        aidx = '{0, 1, 2, 3, 4, 5, 5, 6, 7, 8, 9, 9};

        rst = 1'b1; alu_valid = 1'b0; alu_waddr = '0; alu_data = '0;
        mc_valid = 1'b0; mc_waddr = '0; mc_data = '0; query_addr = 4'd5;
        tick(); tick();
        chk("rst_rf_wen", int'(rf_wen), 0);
        chk("rst_rf_waddr", int'(rf_waddr), 0);
        chk("rst_rf_wdata", int'(rf_wdata), 0);
        chk("rst_pipe_stall", int'(pipe_stall), 0);
        chk("rst_mc_ready", int'(mc_ready), 1);
        chk("rst_pending_hit", int'(pending_hit), 0);
        rst = 1'b0;
        tick();

        // ALU write, one edge of latency.
        n = cyc;
        alu_valid = 1'b1; alu_waddr = 4'd3; alu_data = 16'h1234;
        expect_wr(4'd3, 16'h1234, n + 1);
        tick();
        alu_valid = 1'b0;
        tick();
        chk("alu_wen_drop", int'(rf_wen), 0);

        // Multi-cycle result: queued, visible to hazard probe, written two edges later.
        n = cyc;
        chk("mc_ready_idle", int'(mc_ready), 1);
        mc_valid = 1'b1; mc_waddr = 4'd5; mc_data = 16'hBEEF;
        expect_wr(4'd5, 16'hBEEF, n + 2);
        tick();
        mc_valid = 1'b0; query_addr = 4'd5;
        #1 chk("pend_hit_5", int'(pending_hit), 1);
        tick();
        chk("pend_clear_5", int'(pending_hit), 0);
        tick();

        // ALU saturating the port, FIFO fills, starvation stalls drain it.
        n = cyc;
        for (int i = 0; i < 5; i++) expect_wr(4'd1, 16'h1000 + 16'(i), n + 1 + i);
        expect_wr(4'd8, 16'h0801, n + 6);
        for (int i = 5; i < 9; i++) expect_wr(4'd1, 16'h1000 + 16'(i), n + 2 + i);
        expect_wr(4'd9, 16'h0902, n + 11);
        expect_wr(4'd1, 16'h1009, n + 12);
        for (int t = 0; t < 12; t++) begin
            alu_valid = 1'b1; alu_waddr = 4'd1; alu_data = 16'h1000 + 16'(aidx[t]);
            mc_valid = 1'b0;
            if (t == 0) begin
                mc_valid = 1'b1; mc_waddr = 4'd8; mc_data = 16'h0801;
            end else if (t == 1) begin
                mc_valid = 1'b1; mc_waddr = 4'd9; mc_data = 16'h0902;
            end else if (t == 2) begin
                mc_valid = 1'b1; mc_waddr = 4'd10; mc_data = 16'h0A03;
                chk("mc_ready_full", int'(mc_ready), 0);
                query_addr = 4'd9;
                #1 chk("pend_hit_9", int'(pending_hit), 1);
                query_addr = 4'd10;
                #1 chk("pend_miss_10", int'(pending_hit), 0);
            end
            if (t < 2) chk("mc_ready_fill", int'(mc_ready), 1);
            chk("pipe_stall_seq", int'(pipe_stall), (t == 5 || t == 10) ? 1 : 0);
            tick();
        end
        alu_valid = 1'b0; mc_valid = 1'b0;
        tick(); tick();

        // r0 ALU result is no request: the queued entry takes the port.
        n = cyc;
        alu_valid = 1'b1; alu_waddr = 4'd0; alu_data = 16'hDEAD;
        mc_valid = 1'b1; mc_waddr = 4'd7; mc_data = 16'h00AA;
        expect_wr(4'd7, 16'h00AA, n + 2);
        tick();
        mc_valid = 1'b0; query_addr = 4'd7;
        #1 chk("pend_hit_7", int'(pending_hit), 1);
        tick();
        alu_valid = 1'b0;
        chk("pend_clear_7", int'(pending_hit), 0);
        tick();

        // r0 MC result is consumed without occupying a slot; then fill and stall.
        n = cyc;
        mc_valid = 1'b1; mc_waddr = 4'd0; mc_data = 16'h5555;
        chk("mc_ready_r0", int'(mc_ready), 1);
        tick();
        for (int t = 1; t <= 5; t++) begin
            alu_valid = 1'b1; alu_waddr = 4'd2; alu_data = 16'h2000 + 16'(t);
            expect_wr(4'd2, 16'h2000 + 16'(t), n + t + 1);
            mc_valid = 1'b0;
            if (t == 1) begin
                mc_valid = 1'b1; mc_waddr = 4'd11; mc_data = 16'h0B0B;
                chk("mc_ready_after_r0", int'(mc_ready), 1);
            end else if (t == 2) begin
                mc_valid = 1'b1; mc_waddr = 4'd12; mc_data = 16'h0C0C;
                chk("mc_ready_one", int'(mc_ready), 1);
            end else if (t == 3) begin
                chk("mc_ready_full2", int'(mc_ready), 0);
                query_addr = 4'd12;
                #1 chk("pend_hit_12", int'(pending_hit), 1);
            end
            chk("pipe_stall_pre", int'(pipe_stall), 0);
            tick();
        end

        // Reset lands while full and stalled.
        chk("stall_before_rst", int'(pipe_stall), 1);
        chk("full_before_rst", int'(mc_ready), 0);
        rst = 1'b1; alu_valid = 1'b0; mc_valid = 1'b0;
        tick();
        rst = 1'b0; query_addr = 4'd11;
        chk("rst_mid_wen", int'(rf_wen), 0);
        chk("rst_mid_stall", int'(pipe_stall), 0);
        chk("rst_mid_ready", int'(mc_ready), 1);
        #1 chk("rst_mid_pend", int'(pending_hit), 0);
        for (int i = 0; i < 6; i++) tick();

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
